// File: rtl/audio_frame_sequencer_pkg.sv
// Shared types for the audio frame sequencer: default sample width,
// stereo frame layout and the sequencer state encoding.
package audio_fx_pkg;

    localparam int DATA_W_DEF = 16;

    // Frame layout on the FX bus: right channel in the upper half.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] r;
        logic [DATA_W_DEF-1:0] l;
    } stereo_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FX_SEND = 2'd1,
        FX_WAIT = 2'd2,
        PLAY    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/audio_frame_sequencer_watchdog.sv
// FX watchdog: counts cycles while enabled, holds at TIMEOUT-1 and flags
// expiry there; clear returns it to zero.
module fx_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != TERM)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expire = enable && !clear && (count_reg == TERM);

endmodule

// File: rtl/audio_frame_sequencer.sv
// Pairs ADC left/right samples into a stereo frame, routes it through the
// FX stage (or around it) and plays the result to both DAC channels.
module audio_frame_sequencer
    import audio_fx_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FX_TIMEOUT = 1024,
    parameter int CNT_W      = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                mute,
    input  logic                bypass,
    input  logic [DATA_W-1:0]   adc_l_data,
    input  logic                adc_l_valid,
    output logic                adc_l_ready,
    input  logic [DATA_W-1:0]   adc_r_data,
    input  logic                adc_r_valid,
    output logic                adc_r_ready,
    output logic [2*DATA_W-1:0] fx_in_data,
    output logic                fx_in_valid,
    input  logic                fx_in_ready,
    input  logic [2*DATA_W-1:0] fx_out_data,
    input  logic                fx_out_valid,
    output logic                fx_out_ready,
    output logic [DATA_W-1:0]   dac_l_data,
    output logic                dac_l_valid,
    input  logic                dac_l_ready,
    output logic [DATA_W-1:0]   dac_r_data,
    output logic                dac_r_valid,
    input  logic                dac_r_ready,
    output logic                busy,
    output logic [CNT_W-1:0]    frame_count,
    output logic [7:0]          fx_timeouts
);

    seq_state_t state_reg, state_next;

    // run_reg keeps the ADC readies low while reset is asserted.
    logic              run_reg;
    logic              got_l_reg, got_l_next;
    logic              got_r_reg, got_r_next;
    logic [DATA_W-1:0] dry_l_reg, dry_l_next;
    logic [DATA_W-1:0] dry_r_reg, dry_r_next;
    logic [DATA_W-1:0] play_l_reg, play_l_next;
    logic [DATA_W-1:0] play_r_reg, play_r_next;
    logic              dac_l_valid_reg, dac_l_valid_next;
    logic              dac_r_valid_reg, dac_r_valid_next;
    logic [CNT_W-1:0]  frame_count_reg, frame_count_next;
    logic [7:0]        fx_timeouts_reg, fx_timeouts_next;

    logic              in_fx;
    logic              expire;
    logic              play_load;
    logic              l_cap, r_cap;
    logic [DATA_W-1:0] src_l, src_r;

    assign in_fx = (state_reg == FX_SEND) || (state_reg == FX_WAIT);

    fx_watchdog #(
        .TIMEOUT (FX_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!in_fx),
        .enable  (in_fx),
        .expire  (expire)
    );

    // Handshake outputs are decoded from registered state only.
    assign adc_l_ready  = run_reg && (state_reg == COLLECT) && !got_l_reg;
    assign adc_r_ready  = run_reg && (state_reg == COLLECT) && !got_r_reg;
    assign fx_in_valid  = (state_reg == FX_SEND) && !expire;
    assign fx_out_ready = (state_reg == FX_WAIT) && !expire;
    assign fx_in_data   = {dry_r_reg, dry_l_reg};
    assign dac_l_data   = play_l_reg;
    assign dac_r_data   = play_r_reg;
    assign dac_l_valid  = dac_l_valid_reg;
    assign dac_r_valid  = dac_r_valid_reg;
    assign busy         = (state_reg != COLLECT);
    assign frame_count  = frame_count_reg;
    assign fx_timeouts  = fx_timeouts_reg;

    assign l_cap = adc_l_ready && adc_l_valid;
    assign r_cap = adc_r_ready && adc_r_valid;

    always_comb begin
        state_next       = state_reg;
        play_load        = 1'b0;
        src_l            = dry_l_reg;
        src_r            = dry_r_reg;
        got_l_next       = got_l_reg || l_cap;
        got_r_next       = got_r_reg || r_cap;
        dry_l_next       = l_cap ? adc_l_data : dry_l_reg;
        dry_r_next       = r_cap ? adc_r_data : dry_r_reg;
        dac_l_valid_next = dac_l_valid_reg && !dac_l_ready;
        dac_r_valid_next = dac_r_valid_reg && !dac_r_ready;
        frame_count_next = frame_count_reg;
        fx_timeouts_next = fx_timeouts_reg;

        case (state_reg)
            COLLECT: begin
                if (got_l_reg && got_r_reg) begin
                    got_l_next = 1'b0;
                    got_r_next = 1'b0;
                    if (bypass) begin
                        state_next = PLAY;
                        play_load  = 1'b1;
                    end else begin
                        state_next = FX_SEND;
                    end
                end
            end
            FX_SEND: begin
                if (fx_in_valid && fx_in_ready) begin
                    state_next = FX_WAIT;
                end else if (expire) begin
                    state_next = PLAY;
                    play_load  = 1'b1;
                    if (fx_timeouts_reg != 8'hFF) fx_timeouts_next = fx_timeouts_reg + 8'd1;
                end
            end
            FX_WAIT: begin
                if (fx_out_valid && fx_out_ready) begin
                    state_next = PLAY;
                    play_load  = 1'b1;
                    src_l      = fx_out_data[DATA_W-1:0];
                    src_r      = fx_out_data[2*DATA_W-1:DATA_W];
                end else if (expire) begin
                    state_next = PLAY;
                    play_load  = 1'b1;
                    if (fx_timeouts_reg != 8'hFF) fx_timeouts_next = fx_timeouts_reg + 8'd1;
                end
            end
            PLAY: begin
                if (!dac_l_valid_next && !dac_r_valid_next) begin
                    state_next       = COLLECT;
                    frame_count_next = frame_count_reg + 1'b1;
                end
            end
            default: state_next = COLLECT;
        endcase

        // Mute is captured together with the frame, so later toggles do not
        // disturb a frame that is already playing.
        play_l_next = play_l_reg;
        play_r_next = play_r_reg;
        if (play_load) begin
            play_l_next      = mute ? '0 : src_l;
            play_r_next      = mute ? '0 : src_r;
            dac_l_valid_next = 1'b1;
            dac_r_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_reg         <= 1'b0;
            got_l_reg       <= 1'b0;
            got_r_reg       <= 1'b0;
            dry_l_reg       <= '0;
            dry_r_reg       <= '0;
            play_l_reg      <= '0;
            play_r_reg      <= '0;
            dac_l_valid_reg <= 1'b0;
            dac_r_valid_reg <= 1'b0;
            frame_count_reg <= '0;
            fx_timeouts_reg <= '0;
        end else begin
            run_reg         <= 1'b1;
            got_l_reg       <= got_l_next;
            got_r_reg       <= got_r_next;
            dry_l_reg       <= dry_l_next;
            dry_r_reg       <= dry_r_next;
            play_l_reg      <= play_l_next;
            play_r_reg      <= play_r_next;
            dac_l_valid_reg <= dac_l_valid_next;
            dac_r_valid_reg <= dac_r_valid_next;
            frame_count_reg <= frame_count_next;
            fx_timeouts_reg <= fx_timeouts_next;
        end
    end

endmodule
